// File: rtl/jt51_pkg.sv
// Shared constants and helpers for the jt51 output path.
// Connection codes, datapath widths and 16-bit saturation.
package jt51_pkg;

  localparam int OP_W    = 14;
  localparam int OUT_W   = 16;
  localparam int NOISE_W = 12;

  localparam logic [2:0] CON_0 = 3'd0;
  localparam logic [2:0] CON_1 = 3'd1;
  localparam logic [2:0] CON_2 = 3'd2;
  localparam logic [2:0] CON_3 = 3'd3;
  localparam logic [2:0] CON_4 = 3'd4;
  localparam logic [2:0] CON_5 = 3'd5;
  localparam logic [2:0] CON_6 = 3'd6;
  localparam logic [2:0] CON_7 = 3'd7;

  // Accumulators are sign-extended to 32 bits before the call.
  function automatic logic signed [OUT_W-1:0] sat16(
    input logic signed [31:0] v
  );
    if (v > 32'sd32767)
      return 16'sh7fff;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/jt51_out_lowres.sv
// Floating-point DAC emulation: keeps a 10-bit mantissa,
// scaled by the smallest exponent 0..6 that makes it fit.
module jt51_out_lowres
  import jt51_pkg::*;
(
  input  logic signed [OUT_W-1:0] din,
  output logic signed [OUT_W-1:0] dout
);

  logic [2:0] e;
  logic signed [OUT_W-1:0] sh;

  always_comb begin
    e  = 3'd6;
    sh = '0;
    // Descending scan so the smallest fitting exponent wins.
    for (int i = 6; i >= 0; i--) begin
      sh = din >>> i;
      if (sh >= -16'sd512 && sh <= 16'sd511)
        e = 3'(i);
    end
    dout = (din >>> e) <<< e;
  end

endmodule

// File: rtl/jt51_out_acc.sv
// Per-frame carrier mixer: sums carrier slots into L/R
// accumulators and publishes saturated and low-res samples.
module jt51_out_acc
  import jt51_pkg::*;
#(
  parameter int ACC_W = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic                      m1_enters,
  input  logic                      m2_enters,
  input  logic                      c1_enters,
  input  logic                      c2_enters,
  input  logic                      op31_acc,
  input  logic [1:0]                rl_I,
  input  logic [2:0]                con_I,
  input  logic signed [OP_W-1:0]    op_out,
  input  logic                      ne,
  input  logic signed [NOISE_W-1:0] noise_mix,
  output logic signed [OUT_W-1:0]   left,
  output logic signed [OUT_W-1:0]   right,
  output logic signed [OUT_W-1:0]   xleft,
  output logic signed [OUT_W-1:0]   xright
);

  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [ACC_W-1:0] nxt_l, nxt_r;
  logic signed [ACC_W-1:0] slot_ext;
  logic signed [OP_W-1:0]  slot_val;
  logic signed [OUT_W-1:0] sat_l, sat_r;
  logic signed [OUT_W-1:0] lo_l, lo_r;
  logic sum_en, noise_sel, add_en;

  always_comb begin
    sum_en = 1'b0;
    unique case (con_I)
      CON_0, CON_1, CON_2, CON_3:
        sum_en = c2_enters;
      CON_4:
        sum_en = c1_enters | c2_enters;
      CON_5, CON_6:
        sum_en = c1_enters | m2_enters | c2_enters;
      CON_7:
        sum_en = m1_enters | c1_enters
               | m2_enters | c2_enters;
    endcase
  end

  // Noise replaces slot 31 and bypasses carrier selection.
  assign noise_sel = op31_acc & ne;
  assign slot_val  = noise_sel ? {noise_mix, 2'b00} : op_out;
  assign add_en    = noise_sel | sum_en;
  assign slot_ext  = ACC_W'(slot_val);

  assign nxt_l = acc_l
    + ((add_en && rl_I[0]) ? slot_ext : '0);
  assign nxt_r = acc_r
    + ((add_en && rl_I[1]) ? slot_ext : '0);

  assign sat_l = sat16(32'(nxt_l));
  assign sat_r = sat16(32'(nxt_r));

  jt51_out_lowres u_lo_l (.din(sat_l), .dout(lo_l));
  jt51_out_lowres u_lo_r (.din(sat_r), .dout(lo_r));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l  <= '0;
      acc_r  <= '0;
      xleft  <= '0;
      xright <= '0;
      left   <= '0;
      right  <= '0;
    end else if (cen) begin
      if (op31_acc) begin
        acc_l  <= '0;
        acc_r  <= '0;
        xleft  <= sat_l;
        xright <= sat_r;
        left   <= lo_l;
        right  <= lo_r;
      end else begin
        acc_l <= nxt_l;
        acc_r <= nxt_r;
      end
    end
  end

endmodule

// File: tb/tb_jt51_out_acc.sv
// Scoreboard bench for jt51_out_acc: directed frames push
// expected outputs; a monitor checks them at frame end.
module tb_jt51_out_acc;

  logic clk = 1'b0;
  logic rst, cen;
  logic m1_enters, m2_enters, c1_enters, c2_enters;
  logic op31_acc, ne;
  logic [1:0] rl_I;
  logic [2:0] con_I;
  logic signed [13:0] op_out;
  logic signed [11:0] noise_mix;
  logic signed [15:0] left, right, xleft, xright;

  always #5 clk = ~clk;

  jt51_out_acc #(.ACC_W(19)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .m1_enters(m1_enters), .m2_enters(m2_enters),
    .c1_enters(c1_enters), .c2_enters(c2_enters),
    .op31_acc(op31_acc), .rl_I(rl_I), .con_I(con_I),
    .op_out(op_out), .ne(ne), .noise_mix(noise_mix),
    .left(left), .right(right),
    .xleft(xleft), .xright(xright)
  );

  typedef struct {
    string name;
    logic signed [15:0] xl, xr, l, r;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  logic [2:0] fcon[8];
  logic [1:0] frl[8];
  logic signed [13:0] fop[32];
  logic fne;
  logic signed [11:0] fnm;

  task automatic chk(input string nm,
                     input logic signed [15:0] act,
                     input logic signed [15:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d required %0d",
                  nm, act, req);
  endtask

  // Monitor: outputs are valid the clock after op31_acc&cen.
  logic pend = 1'b0;
  always @(posedge clk) pend <= cen & op31_acc & ~rst;

  always @(negedge clk) begin
    if (pend) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_frame: got output, required none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".xleft"},  xleft,  e.xl);
        chk({e.name, ".xright"}, xright, e.xr);
        chk({e.name, ".left"},   left,   e.l);
        chk({e.name, ".right"},  right,  e.r);
      end
    end
  end

  task automatic clr();
    for (int i = 0; i < 8; i++) begin
      fcon[i] = 3'd0;
      frl[i] = 2'b00;
    end
    for (int i = 0; i < 32; i++) fop[i] = '0;
    fne = 1'b0;
    fnm = '0;
  endtask

  task automatic idle();
    cen = 1'b0;
    m1_enters = 0; m2_enters = 0;
    c1_enters = 0; c2_enters = 0;
    op31_acc = 0; ne = 0;
    rl_I = 0; con_I = 0;
    op_out = '0; noise_mix = '0;
  endtask

  task automatic push(input string nm,
                      input int xl, input int xr,
                      input int l, input int r);
    exp_t e;
    e.name = nm;
    e.xl = 16'(xl); e.xr = 16'(xr);
    e.l = 16'(l);   e.r = 16'(r);
    sb.push_back(e);
  endtask

  // Slot order: 0-7 M1, 8-15 M2, 16-23 C1, 24-31 C2.
  task automatic run(input int nslots, input int stall_at);
    for (int s = 0; s < nslots; s++) begin
      if (s == stall_at) begin
        @(negedge clk);
        cen = 1'b0;
        op_out = 14'sd7777;
        op31_acc = 1'b1;
        c2_enters = 1'b1;
        con_I = 3'd7;
        rl_I = 2'b11;
        repeat (10) @(posedge clk);
      end
      @(negedge clk);
      cen = 1'b1;
      m1_enters = (s / 8 == 0);
      m2_enters = (s / 8 == 1);
      c1_enters = (s / 8 == 2);
      c2_enters = (s / 8 == 3);
      op31_acc = (s == 31);
      con_I = fcon[s % 8];
      rl_I = frl[s % 8];
      op_out = fop[s];
      ne = fne;
      noise_mix = fnm;
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    clr();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset.xleft", xleft, 16'sd0);
    chk("reset.xright", xright, 16'sd0);
    chk("reset.left", left, 16'sd0);
    chk("reset.right", right, 16'sd0);

    clr();
    fcon[0] = 3'd7; frl[0] = 2'b11;
    fop[0] = 100; fop[8] = 100; fop[16] = 100; fop[24] = 100;
    push("con7", 400, 400, 400, 400);
    run(32, -1);

    clr();
    fcon[0] = 3'd0; frl[0] = 2'b01;
    fop[0] = 1000; fop[8] = 1000; fop[16] = 1000;
    fop[24] = -300;
    push("con0", -300, 0, -300, 0);
    run(32, -1);

    clr();
    for (int i = 0; i < 8; i++) begin
      fcon[i] = 3'd7; frl[i] = 2'b11;
    end
    for (int i = 0; i < 32; i++) fop[i] = 14'sd8191;
    push("sat_hi", 32767, 32767, 32704, 32704);
    run(32, -1);
    for (int i = 0; i < 32; i++) fop[i] = -14'sd8192;
    push("sat_lo", -32768, -32768, -32768, -32768);
    run(32, -1);

    clr();
    fcon[7] = 3'd0; frl[7] = 2'b10;
    fop[31] = 5000; fne = 1'b1; fnm = 12'sd256;
    push("noise", 0, 1024, 0, 1024);
    run(32, -1);

    clr();
    fcon[1] = 3'd4; frl[1] = 2'b10;
    fop[1] = 50; fop[9] = 60; fop[17] = 70; fop[25] = 80;
    fcon[2] = 3'd5; frl[2] = 2'b01;
    fop[2] = 10; fop[10] = 20; fop[18] = 30; fop[26] = 40;
    fcon[3] = 3'd7; frl[3] = 2'b11;
    fop[3] = 1; fop[11] = 1; fop[19] = 1; fop[27] = 1;
    push("mixed", 94, 154, 94, 154);
    run(32, -1);

    clr();
    fcon[0] = 3'd0; frl[0] = 2'b01;
    fop[24] = 1001;
    push("lo_1001", 1001, 0, 1000, 0);
    run(32, -1);
    fop[24] = -3;
    push("lo_m3", -3, 0, -3, 0);
    run(32, -1);
    fop[24] = 5000;
    push("lo_5000", 5000, 0, 4992, 0);
    run(32, -1);

    clr();
    fcon[0] = 3'd7; frl[0] = 2'b11;
    for (int i = 0; i < 16; i++) fop[i] = 500;
    run(16, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.xleft", xleft, 16'sd0);
    chk("midrst.xright", xright, 16'sd0);
    chk("midrst.left", left, 16'sd0);
    chk("midrst.right", right, 16'sd0);
    clr();
    push("after_rst", 0, 0, 0, 0);
    run(32, -1);

    clr();
    fcon[0] = 3'd7; frl[0] = 2'b11;
    fop[0] = 100; fop[8] = 100; fop[16] = 100; fop[24] = 100;
    push("cen_stall", 400, 400, 400, 400);
    run(32, 10);

    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending, required 0",
               sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jt51_out_acc.md
Name: jt51_out_acc

Overview:
- Output accumulator/mixer of the YM2151-compatible FM core.
- Receives one operator sample per slot (32 slots per sample frame: 8 channels × M1, C1, M2, C2).
- Sums only carrier operators of each channel's algorithm into left/right accumulators, substituting the noise generator output in slot 31 when noise is enabled.
- Once per frame, publishes saturated full-resolution outputs plus a low-resolution version that mimics the real chip's floating-point DAC.

Parameters:
- ACC_W, 19: accumulator width in bits (signed); must hold 32 × 14-bit worst case.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cen  in  1  clock enable; all state advances only when cen=1
- m1_enters  in  1  current slot is an M1 operator
- m2_enters  in  1  current slot is an M2 operator
- c1_enters  in  1  current slot is a C1 operator
- c2_enters  in  1  current slot is a C2 operator
- op31_acc  in  1  current slot is slot 31 (channel 7 C2), the last slot of the frame
- rl_I  in  2  channel output enables: bit0 = left, bit1 = right
- con_I  in  3  channel algorithm (connection) 0..7
- op_out  in  14  signed operator output for current slot
- ne  in  1  noise enable
- noise_mix  in  12  signed noise sample
- left  out  16  signed low-resolution left sample
- right  out  16  signed low-resolution right sample
- xleft  out  16  signed full-resolution left sample
- xright  out  16  signed full-resolution right sample

Behaviour:
- All inputs are aligned to the same cen cycle; exactly one *_enters flag is high per slot.
- Carrier selection (sum_en) by con_I:
  - 0–3: c2_enters only.
  - 4: c1_enters | c2_enters.
  - 5, 6: any slot except M1 (c1 | m2 | c2).
  - 7: all slots.
- Slot value:
  - If op31_acc & ne: {noise_mix, 2'b00} as signed 14-bit; replaces op_out and is summed regardless of con_I.
  - Otherwise: op_out, summed only when sum_en.
- Each summed value is sign-extended to ACC_W and added to acc_l if rl_I[0], and to acc_r if rl_I[1].
- Frame end, on the cen cycle with op31_acc=1:
  - Final sums include slot 31.
  - xleft/xright are registered with the final sums saturated to [-32768, 32767].
  - Accumulators reload with 0.
  - Outputs appear the clock after that cen cycle and hold for the whole next frame.
- Low-resolution output (left/right), registered in the same clock as xleft/xright:
  - Input v is the saturated value.
  - e is the smallest value in 0..6 such that v>>>e fits a 10-bit signed range [-512, 511].
  - Output is (v>>>e)<<e, i.e. 10-bit mantissa, 3-bit exponent, truncation toward −∞.
- cen=0: no state change; outputs hold.
- Reset: acc_l, acc_r, left, right, xleft, xright all 0. Reset mid-frame discards the partial sums; the first frame after reset starts from 0.
- Arithmetic is two's complement throughout. There is no intermediate overflow check, since ACC_W=19 covers 32×(±8192).

Decomposition:
- Shared package jt51_pkg:
  - Connection constants CON_0..CON_7.
  - Widths OP_W=14, OUT_W=16, NOISE_W=12.
  - Function sat16 (saturate ACC_W to 16 bits).
- One sub-module jt51_out_lowres: combinational 16-bit → 10-bit-mantissa quantizer, instantiated twice (left, right).

Test Plan:
- Frame where channel 0 has con=7, rl=11, all four slots op_out=100, all other slots op_out=0 → after op31_acc: xleft=xright=400, left=right=400.
- Channel 0 con=0, rl=01; M1/C1/M2 op_out=1000, C2 op_out=-300; rest 0 → xleft=-300, xright=0.
- All 32 slots con=7, rl=11, op_out=8191 → xleft=xright=32767; with op_out=-8192 → -32768.
- ne=1, noise_mix=12'sd256 at slot 31, channel 7 con=0, rl=10, op_out=5000 at slot 31, rest 0 → xright=1024, xleft=0.
- Low-res check: single carrier op_out=1001 → xleft=1001, left=1000; op_out=-3 → left=-3; op_out=5000 → left=4992.
- Assert rst mid-frame after several nonzero slots, then run a frame of zeros → outputs 0. Hold cen=0 for 10 clocks mid-frame → result identical to an uninterrupted frame.
